// File: rtl/sd_cmd_deserializer_if.sv
// Bus between the SD CMD line receiver and the host command logic.
// The host side (master) arms the receiver and drives the sampled CMD line;
// the receiver side (slave) returns the captured frame and its status flags.
interface sd_cmd_deserializer_if #(
    parameter int BITS = 48
);
    logic            enable;
    logic            in;
    logic [BITS-1:0] out;
    logic            complete;
    logic            timeout;
    logic            crc_err;
    logic            frame_err;

    modport master (
        output enable, in,
        input  out, complete, timeout, crc_err, frame_err
    );

    modport slave (
        input  enable, in,
        output out, complete, timeout, crc_err, frame_err
    );
endinterface

// File: rtl/sd_cmd_deserializer.sv
// SD CMD line receiver: waits for a response start bit, shifts in a BITS-wide
// frame (first wire bit -> out[0]), checks CRC7 and the end bit.
//
// Handshake: there is no valid/ready pair. The host raises enable to arm the
// receiver and keeps it high; the receiver then raises exactly one of complete
// or timeout and holds it (with out/crc_err/frame_err) until the host drops
// enable. Dropping enable for at least one edge returns to IDLE, clears the
// flags and is the only way to re-arm.
module sd_cmd_deserializer #(
    parameter int BITS         = 48,
    parameter int BITS_COUNTER = 8,
    parameter int TIMEOUT      = 64,
    parameter int TIMEOUT_BITS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    sd_cmd_deserializer_if.slave bus,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECEIVE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [BITS_COUNTER-1:0] LAST_BIT = BITS_COUNTER'(BITS - 1);
    localparam logic [BITS_COUNTER-1:0] CRC_LAST = BITS_COUNTER'(BITS - 9);
    localparam logic [BITS_COUNTER-1:0] CRC_R2_FIRST = BITS_COUNTER'(8);
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST  = TIMEOUT_BITS'(TIMEOUT - 1);

    state_t                  state, state_next;
    logic [BITS-1:0]         out_q;
    logic [BITS_COUNTER-1:0] count;
    logic [TIMEOUT_BITS-1:0] tcount;
    logic [6:0]              crc;
    logic [6:0]              rx_crc;
    logic                    complete_q, timeout_q, crc_err_q, frame_err_q;
    logic                    crc_feed;
    logic                    do_arm, do_start, do_wait, do_shift, do_drop;

    // One step of CRC7 (x^7 + x^3 + 1), MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // Long (R2) responses exclude start, direction and reserved bits from the CRC.
    generate
        if (BITS > 48) begin : g_crc_long
            assign crc_feed = (count >= CRC_R2_FIRST) && (count <= CRC_LAST);
        end else begin : g_crc_short
            assign crc_feed = (count <= CRC_LAST);
        end
    endgenerate

    // Received CRC field, first-arrived bit is the CRC MSB.
    always_comb begin
        rx_crc = '0;
        for (int k = 0; k < 7; k++) begin
            rx_crc[6-k] = out_q[BITS-8+k];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; enable low wins from every state.
    always_comb begin
        state_next = state;
        if (!bus.enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:       state_next = WAIT_START;
                WAIT_START: if (!bus.in)              state_next = RECEIVE;
                            else if (tcount == TO_LAST) state_next = DONE;
                RECEIVE:    if (count == LAST_BIT)    state_next = DONE;
                default:    state_next = DONE;
            endcase
        end
    end

    // Control strobes decoded from state and inputs.
    always_comb begin
        do_drop  = !bus.enable;
        do_arm   = bus.enable && (state == IDLE);
        do_start = bus.enable && (state == WAIT_START) && !bus.in;
        do_wait  = bus.enable && (state == WAIT_START) && bus.in;
        do_shift = bus.enable && (state == RECEIVE);
    end

    // Datapath: frame shift register, counters, CRC and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            count       <= '0;
            tcount      <= '0;
            crc         <= '0;
            complete_q  <= 1'b0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (do_drop) begin
            complete_q  <= 1'b0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (do_arm) begin
            out_q       <= '0;
            count       <= '0;
            tcount      <= '0;
            crc         <= '0;
            complete_q  <= 1'b0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (do_start) begin
            // A zero start bit through a zero CRC leaves the CRC at zero.
            out_q[0] <= 1'b0;
            count    <= BITS_COUNTER'(1);
            crc      <= '0;
        end else if (do_wait) begin
            tcount <= tcount + 1'b1;
            if (tcount == TO_LAST) timeout_q <= 1'b1;
        end else if (do_shift) begin
            for (int i = 0; i < BITS; i++) begin
                if (count == BITS_COUNTER'(i)) out_q[i] <= bus.in;
            end
            count <= count + 1'b1;
            if (crc_feed) crc <= crc7_step(crc, bus.in);
            if (count == LAST_BIT) begin
                complete_q  <= 1'b1;
                crc_err_q   <= (crc != rx_crc);
                frame_err_q <= ~bus.in;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.complete  = complete_q;
    assign bus.timeout   = timeout_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.frame_err = frame_err_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_sd_cmd_deserializer.sv
// Directed bench for sd_cmd_deserializer: known SD responses, CRC and end-bit
// errors, start-bit timeout, loopback of random words, abort/re-arm and reset.
module tb_sd_cmd_deserializer;
    localparam int BITS = 48;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;
    int         errors = 0;
    int         checks = 0;
    logic [BITS-1:0] exp_q[$];
    logic [BITS-1:0] f1, f2, f3, wl, wa;

    sd_cmd_deserializer_if #(.BITS(BITS)) bus ();

    sd_cmd_deserializer #(
        .BITS(BITS), .BITS_COUNTER(8), .TIMEOUT(64), .TIMEOUT_BITS(7)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Single comparison point.
    task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Line value written MSB-first -> word with first wire bit in [0].
    function automatic logic [BITS-1:0] line_to_word(input logic [BITS-1:0] v);
        logic [BITS-1:0] w;
        for (int i = 0; i < BITS; i++) w[i] = v[BITS-1-i];
        return w;
    endfunction

    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // Random valid response word as the serializer would present it.
    function automatic logic [BITS-1:0] make_word();
        logic [BITS-1:0] w;
        logic [6:0] c;
        w = '0;
        w[1] = 1'b1;
        for (int i = 2; i < BITS - 8; i++) w[i] = 1'($urandom_range(0, 1));
        c = '0;
        for (int i = 0; i < BITS - 8; i++) c = crc_step(c, w[i]);
        for (int k = 0; k < 7; k++) w[BITS-8+k] = c[6-k];
        w[BITS-1] = 1'b1;
        return w;
    endfunction

    // Driver tasks; all start and end at a falling edge.
    task automatic arm();
        bus.enable = 1'b1;
        bus.in     = 1'b1;
        @(negedge clk);
    endtask

    task automatic disarm();
        bus.enable = 1'b0;
        bus.in     = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) begin
            bus.in = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic send_bits(input logic [BITS-1:0] w, input int first, input int last);
        for (int i = first; i < last; i++) begin
            bus.in = w[i];
            @(negedge clk);
            if (i == BITS - 2) check("no_early_complete", BITS'(bus.complete), '0);
        end
    endtask

    // Scoreboard: compare a finished frame against the queued expectation.
    task automatic check_frame(input string tag, input logic crc_e, input logic frm_e);
        logic [BITS-1:0] e;
        check({tag, "_sb_pending"}, BITS'(exp_q.size()), BITS'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_out"}, bus.out, e);
        end
        check({tag, "_complete"},  BITS'(bus.complete),  BITS'(1));
        check({tag, "_crc_err"},   BITS'(bus.crc_err),   BITS'(crc_e));
        check({tag, "_frame_err"}, BITS'(bus.frame_err), BITS'(frm_e));
        check({tag, "_timeout"},   BITS'(bus.timeout),   '0);
        check({tag, "_state"},     BITS'(state_dbg),     BITS'(S_DONE));
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.in     = 1'b1;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out",       bus.out,               '0);
        check("rst_complete",  BITS'(bus.complete),   '0);
        check("rst_timeout",   BITS'(bus.timeout),    '0);
        check("rst_crc_err",   BITS'(bus.crc_err),    '0);
        check("rst_frame_err", BITS'(bus.frame_err),  '0);
        check("rst_state",     BITS'(state_dbg),      BITS'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // CMD0-style response with correct CRC 0x4A and end bit.
        f1 = line_to_word(48'h40_0000_0000_95);
        arm();
        idle_bits(3);
        exp_q.push_back(f1);
        send_bits(f1, 0, BITS);
        check_frame("t1", 1'b0, 1'b0);
        check("t1_bit0",  BITS'(bus.out[0]),  '0);
        check("t1_bit1",  BITS'(bus.out[1]),  BITS'(1));
        check("t1_bit47", BITS'(bus.out[47]), BITS'(1));
        // DONE ignores the line and does not re-arm while enable stays high.
        send_bits('0, 0, 4);
        check("t1_hold_out",      bus.out,             f1);
        check("t1_hold_complete", BITS'(bus.complete), BITS'(1));
        check("t1_hold_state",    BITS'(state_dbg),    BITS'(S_DONE));
        disarm();
        check("t1_drop_complete", BITS'(bus.complete), '0);
        check("t1_drop_out",      bus.out,             f1);
        check("t1_drop_state",    BITS'(state_dbg),    BITS'(S_IDLE));

        // Same frame with payload bit 20 flipped -> CRC error.
        f2 = f1 ^ (BITS'(1) << 20);
        arm();
        idle_bits(1);
        exp_q.push_back(f2);
        send_bits(f2, 0, BITS);
        check_frame("t2", 1'b1, 1'b0);
        disarm();

        // CMD17-style response, good CRC 0x2A, end bit forced low.
        f3 = line_to_word(48'h51_0000_0000_55);
        f3[BITS-1] = 1'b0;
        arm();
        idle_bits(2);
        exp_q.push_back(f3);
        send_bits(f3, 0, BITS);
        check_frame("t3", 1'b0, 1'b1);
        disarm();

        // Timeout: line high for 64 edges after arm.
        arm();
        idle_bits(63);
        check("t4_to_early", BITS'(bus.timeout), '0);
        check("t4_wait",     BITS'(state_dbg),   BITS'(S_WAIT));
        idle_bits(1);
        check("t4_timeout",  BITS'(bus.timeout),  BITS'(1));
        check("t4_complete", BITS'(bus.complete), '0);
        check("t4_out",      bus.out,             '0);
        check("t4_state",    BITS'(state_dbg),    BITS'(S_DONE));
        disarm();
        check("t4_drop_timeout", BITS'(bus.timeout), '0);

        // Start bit on the 64th edge wins over the timeout.
        arm();
        idle_bits(63);
        exp_q.push_back(f1);
        send_bits(f1, 0, 1);
        check("t4b_timeout", BITS'(bus.timeout), '0);
        check("t4b_state",   BITS'(state_dbg),   BITS'(S_RECV));
        send_bits(f1, 1, BITS);
        check_frame("t4b", 1'b0, 1'b0);
        disarm();

        // Loopback of a random serializer word.
        wl = make_word();
        arm();
        idle_bits(2);
        exp_q.push_back(wl);
        send_bits(wl, 0, BITS);
        check_frame("loop", 1'b0, 1'b0);
        disarm();

        // Abort at bit 20, then re-arm and receive cleanly.
        wa = make_word();
        arm();
        idle_bits(1);
        send_bits(wa, 0, 20);
        disarm();
        check("abort_state",    BITS'(state_dbg),    BITS'(S_IDLE));
        check("abort_complete", BITS'(bus.complete), '0);
        arm();
        idle_bits(1);
        exp_q.push_back(wa);
        send_bits(wa, 0, BITS);
        check_frame("rearm", 1'b0, 1'b0);
        disarm();

        // Asynchronous reset between edges in the middle of a frame.
        arm();
        idle_bits(1);
        send_bits(f1, 0, 20);
        #2;
        reset = 1'b1;
        #1;
        check("areset_out",      bus.out,             '0);
        check("areset_state",    BITS'(state_dbg),    BITS'(S_IDLE));
        check("areset_complete", BITS'(bus.complete), '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // Earliest start: first edge after the arm edge.
        arm();
        exp_q.push_back(f1);
        send_bits(f1, 0, BITS);
        check_frame("post_reset", 1'b0, 1'b0);
        disarm();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
